my_axi4_lite_slave: RTL and testbench

MY_AXI4_LITE_SLAVE -- requirements
Module: my_axi4_lite_slave

---
 rtl/my_axi4_lite_pkg.sv | 17 +
 rtl/my_axi4_lite_addr_decode.sv | 25 ++
 rtl/my_axi4_lite_slave.sv | 192 +++++++++++++++++++
 tb/tb_my_axi4_lite_slave.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_axi4_lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register slave.
package my_axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/my_axi4_lite_addr_decode.sv
// Combinational address decode: byte address -> register index and range flag.
module my_axi4_lite_addr_decode #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000_0000
) (
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  output logic [$clog2(REG_NUM)-1:0] idx_o,
  output logic                       in_range_o
);

  localparam int unsigned           LSB  = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH + 1)'(REG_NUM * (DATA_WIDTH / 8));

  logic [ADDR_WIDTH:0] offset;

  // One extra bit keeps addresses below BASE_ADDR from wrapping into range.
  always_comb begin
    offset     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    in_range_o = !offset[ADDR_WIDTH] && (offset < SPAN);
    idx_o      = offset[LSB +: $clog2(REG_NUM)];
  end

endmodule

// File: rtl/my_axi4_lite_slave.sv
// AXI4-Lite slave exposing REG_NUM byte-writable registers with a write-strobe pulse.
module my_axi4_lite_slave
  import my_axi4_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000_0000
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_out,
  output logic                          wr_pulse,
  output logic [$clog2(REG_NUM)-1:0]    wr_index
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(REG_NUM);

  wstate_e               wstate_q;
  rstate_e               rstate_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic                  aw_done_q, w_done_q, aw_ok_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  wr_pulse_q;
  logic [IDX_W-1:0]      wr_index_q;
  logic                  arready_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  aw_in_range, ar_in_range;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  my_axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .BASE_ADDR  (BASE_ADDR)
  ) u_aw_decode (
    .addr_i     (s_axi_awaddr),
    .idx_o      (aw_idx),
    .in_range_o (aw_in_range)
  );

  my_axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .BASE_ADDR  (BASE_ADDR)
  ) u_ar_decode (
    .addr_i     (s_axi_araddr),
    .idx_o      (ar_idx),
    .in_range_o (ar_in_range)
  );

  // Write FSM: latch AW and W independently, commit once both are held, then respond.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wstate_q   <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_ok_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      unique case (wstate_q)
        W_IDLE: begin
          if (aw_done_q && w_done_q) begin
            if (aw_ok_q) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
              end
              wr_pulse_q <= 1'b1;
              wr_index_q <= aw_idx_q;
              bresp_q    <= RESP_OKAY;
            end else begin
              bresp_q    <= RESP_SLVERR;
            end
            bvalid_q <= 1'b1;
            wstate_q <= W_RESP;
          end else begin
            if (s_axi_awvalid && awready_q) begin
              aw_done_q <= 1'b1;
              awready_q <= 1'b0;
              aw_idx_q  <= aw_idx;
              aw_ok_q   <= aw_in_range;
            end
            if (s_axi_wvalid && wready_q) begin
              w_done_q <= 1'b1;
              wready_q <= 1'b0;
              wdata_q  <= s_axi_wdata;
              wstrb_q  <= s_axi_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read FSM: sample the register at the AR handshake edge and hold until accepted.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      unique case (rstate_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            rdata_q   <= ar_in_range ? regs_q[ar_idx] : '0;
            rresp_q   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Flatten the register file onto the reg_out bus.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_index      = wr_index_q;

endmodule

// File: tb/tb_my_axi4_lite_slave.sv
// Scoreboard-driven bench for my_axi4_lite_slave with default parameters.
module tb_my_axi4_lite_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned RN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr;
  logic [3:0]    wstrb;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [RN*DW-1:0] reg_out;
  logic          wr_pulse;
  logic [3:0]    wr_index;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic [1:0]  exp_b_q [$];
  rexp_t       exp_r_q [$];
  logic [31:0] model [RN];

  always #5 clk = ~clk;

  my_axi4_lite_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .REG_NUM    (16),
    .BASE_ADDR  (32'h1000_0000)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'b000),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'b000),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse),
    .wr_index      (wr_index)
  );

  // Reference model: 64-bit address arithmetic, 16 word registers from 0x1000_0000.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    longint unsigned a;
    int unsigned k;
    a = addr;
    if (a >= 64'h1000_0000 && (a - 64'h1000_0000) < 64) begin
      k = int'((a - 64'h1000_0000) / 4);
      for (int b = 0; b < 4; b++) if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr);
    longint unsigned a;
    rexp_t r;
    a = addr;
    if (a >= 64'h1000_0000 && (a - 64'h1000_0000) < 64) begin
      r.resp = 2'b00;
      r.data = model[int'((a - 64'h1000_0000) / 4)];
    end else begin
      r.resp = 2'b10;
      r.data = 32'h0;
    end
    return r;
  endfunction

  function automatic logic [RN*DW-1:0] model_vec();
    logic [RN*DW-1:0] v;
    for (int i = 0; i < RN; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  // Drives one write; W leads AW by wlead cycles; bready raised bdelay cycles after bvalid.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int wlead, input int bdelay,
                          output logic [1:0] br, output logic pulse_seen, output logic [3:0] pidx,
                          output logic early_b, output logic to);
    int   cyc;
    logic aw_s, w_s, hs_aw, hs_w;
    to = 1'b0; pulse_seen = 1'b0; pidx = '0; early_b = 1'b0; br = 2'bxx;
    aw_s = 1'b0; w_s = 1'b0; cyc = 0;
    @(negedge clk);
    wdata = data; wstrb = strb; wvalid = 1'b1;
    awaddr = addr; awvalid = (wlead == 0);
    while (!(aw_s && w_s)) begin
      if (cyc > 50) begin to = 1'b1; break; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (bvalid && !aw_s) early_b = 1'b1;
      if (wr_pulse) pulse_seen = 1'b1;
      if (hs_aw) begin aw_s = 1'b1; awvalid = 1'b0; end
      if (hs_w)  begin w_s = 1'b1;  wvalid = 1'b0; end
      if (!aw_s && cyc >= wlead) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!to && !bvalid && cyc < 50) begin
      if (wr_pulse) pulse_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!bvalid) to = 1'b1;
    else begin
      br = bresp;
      if (wr_pulse) begin pulse_seen = 1'b1; pidx = wr_index; end
      repeat (bdelay) @(negedge clk);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  // Drives one read and holds rready low for stall cycles, watching the response stay put.
  task automatic do_read(input logic [31:0] addr, input int stall,
                         output logic [1:0] rr, output logic [31:0] rd,
                         output logic hold_ok, output logic ar_back, output logic to);
    int cyc;
    to = 1'b0; hold_ok = 1'b1; ar_back = 1'b0; rr = 2'bxx; rd = 'x;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; cyc = 0;
    while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 1'b0;
    if (!rvalid) begin to = 1'b1; return; end
    rr = rresp; rd = rdata;
    repeat (stall) begin
      @(negedge clk);
      if (!rvalid || rdata !== rd || rresp !== rr || arready) hold_ok = 1'b0;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    ar_back = arready && !rvalid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_readies got=%b want=111", {awready, wready, arready});
    end
    n_checks++;
    if ({bvalid, rvalid, wr_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids got=%b want=000", {bvalid, rvalid, wr_pulse});
    end
    n_checks++;
    if ({bresp, rresp, rdata, wr_index} !== 40'h0) begin
      n_fail++; $display("FAIL reset_resp_data got=%h want=0", {bresp, rresp, rdata, wr_index});
    end
    n_checks++;
    if (reg_out !== '0) begin
      n_fail++; $display("FAIL reset_reg_out got=%h want=0", reg_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_same_cycle;
    logic [1:0] br, eb; logic ps, eo, to; logic [3:0] pi;
    exp_b_q.push_back(model_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF));
    do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, br, ps, pi, eo, to);
    eb = exp_b_q.pop_front();
    n_checks++;
    if (to || br !== eb) begin n_fail++; $display("FAIL same_cycle_bresp got=%b want=%b to=%b", br, eb, to); end
    n_checks++;
    if (!ps || pi !== 4'd1) begin n_fail++; $display("FAIL same_cycle_pulse got=%b/%0d want=1/1", ps, pi); end
    n_checks++;
    if (reg_out[1*DW +: DW] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL same_cycle_reg1 got=%h want=deadbeef", reg_out[1*DW +: DW]);
    end
  endtask

  task automatic test_w_before_aw;
    logic [1:0] br, eb; logic ps, eo, to; logic [3:0] pi;
    exp_b_q.push_back(model_write(32'h1000_0004, 32'h0000_00AA, 4'h1));
    do_write(32'h1000_0004, 32'h0000_00AA, 4'h1, 2, 1, br, ps, pi, eo, to);
    eb = exp_b_q.pop_front();
    n_checks++;
    if (to || br !== eb || eo) begin
      n_fail++; $display("FAIL w_first_bresp got=%b want=%b early_bvalid=%b", br, eb, eo);
    end
    n_checks++;
    if (reg_out !== model_vec() || reg_out[1*DW +: DW] !== 32'hDEAD_BEAA) begin
      n_fail++; $display("FAIL w_first_reg1 got=%h want=deadbeaa", reg_out[1*DW +: DW]);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] addrs [2];
    logic [1:0] br, eb, rr; logic ps, eo, to, hk, ab; logic [3:0] pi; logic [31:0] rd;
    rexp_t er;
    addrs[0] = 32'h1000_0040;
    addrs[1] = 32'h0FFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      exp_b_q.push_back(model_write(addrs[i], 32'hFFFF_FFFF, 4'hF));
      do_write(addrs[i], 32'hFFFF_FFFF, 4'hF, 0, 0, br, ps, pi, eo, to);
      eb = exp_b_q.pop_front();
      n_checks++;
      if (to || br !== eb || ps) begin
        n_fail++; $display("FAIL oor_write_%0d got=%b pulse=%b want=%b pulse=0", i, br, ps, eb);
      end
      n_checks++;
      if (reg_out !== model_vec()) begin
        n_fail++; $display("FAIL oor_reg_out_%0d got=%h want=%h", i, reg_out, model_vec());
      end
      exp_r_q.push_back(model_read(addrs[i]));
      do_read(addrs[i], 0, rr, rd, hk, ab, to);
      er = exp_r_q.pop_front();
      n_checks++;
      if (to || rr !== er.resp || rd !== er.data) begin
        n_fail++; $display("FAIL oor_read_%0d got=%b/%h want=%b/%h", i, rr, rd, er.resp, er.data);
      end
    end
  endtask

  task automatic test_read_stall;
    logic [1:0] rr; logic [31:0] rd; logic hk, ab, to; rexp_t er;
    exp_r_q.push_back(model_read(32'h1000_0004));
    do_read(32'h1000_0004, 5, rr, rd, hk, ab, to);
    er = exp_r_q.pop_front();
    n_checks++;
    if (to || rr !== er.resp || rd !== er.data) begin
      n_fail++; $display("FAIL stall_read got=%b/%h want=%b/%h", rr, rd, er.resp, er.data);
    end
    n_checks++;
    if (!hk || !ab) begin n_fail++; $display("FAIL stall_hold got=%b/%b want=1/1", hk, ab); end
  endtask

  task automatic test_collision;
    logic [1:0] eb; rexp_t er;
    exp_r_q.push_back(model_read(32'h1000_0008));
    exp_b_q.push_back(model_write(32'h1000_0008, 32'h1234_5678, 4'hF));
    @(negedge clk);
    awaddr = 32'h1000_0008; awvalid = 1'b1;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    n_checks++;
    if (!(awready && wready && arready)) begin
      n_fail++; $display("FAIL collide_idle got=%b want=111", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h1000_0008; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    er = exp_r_q.pop_front();
    eb = exp_b_q.pop_front();
    n_checks++;
    if (!rvalid || rresp !== er.resp || rdata !== er.data) begin
      n_fail++; $display("FAIL collide_read got=%b/%b/%h want=1/%b/%h", rvalid, rresp, rdata, er.resp, er.data);
    end
    n_checks++;
    if (!bvalid || bresp !== eb || !wr_pulse || wr_index !== 4'd2) begin
      n_fail++; $display("FAIL collide_write got=%b/%b/%b/%0d want=1/%b/1/2", bvalid, bresp, wr_pulse, wr_index, eb);
    end
    n_checks++;
    if (reg_out !== model_vec()) begin
      n_fail++; $display("FAIL collide_reg2 got=%h want=12345678", reg_out[2*DW +: DW]);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int first, second;
    logic hs, bh;
    logic [1:0] br, eb;
    first = -1; second = -1;
    exp_b_q.push_back(model_write(32'h1000_000C, 32'hA5A5_0003, 4'hF));
    exp_b_q.push_back(model_write(32'h1000_0010, 32'h5A5A_0004, 4'hF));
    @(negedge clk);
    bready = 1'b1;
    awaddr = 32'h1000_000C; awvalid = 1'b1;
    wdata = 32'hA5A5_0003; wstrb = 4'hF; wvalid = 1'b1;
    for (int c = 0; c < 20 && second < 0; c++) begin
      hs = awvalid && awready && wvalid && wready;
      bh = bvalid && bready;
      br = bresp;
      @(negedge clk);
      if (bh) begin
        eb = exp_b_q.pop_front();
        n_checks++;
        if (br !== eb) begin n_fail++; $display("FAIL b2b_bresp_first got=%b want=%b", br, eb); end
      end
      if (hs) begin
        if (first < 0) begin
          first = c; awaddr = 32'h1000_0010; wdata = 32'h5A5A_0004;
        end else begin
          second = c; awvalid = 1'b0; wvalid = 1'b0;
        end
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bvalid) begin
        br = bresp;
        @(negedge clk);
        eb = exp_b_q.pop_front();
        n_checks++;
        if (br !== eb) begin n_fail++; $display("FAIL b2b_bresp_second got=%b want=%b", br, eb); end
        break;
      end
      @(negedge clk);
    end
    bready = 1'b0;
    n_checks++;
    if (first < 0 || second < 0 || (second - first) != 3) begin
      n_fail++; $display("FAIL b2b_spacing got=%0d want=3", second - first);
    end
    n_checks++;
    if (exp_b_q.size() != 0 || reg_out !== model_vec()) begin
      n_fail++; $display("FAIL b2b_regs pending=%0d got=%h want=%h", exp_b_q.size(), reg_out, model_vec());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    awaddr = 32'h1000_0014; awvalid = 1'b1;
    wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++;
    if (!bvalid) begin n_fail++; $display("FAIL midrst_bvalid_wait got=0 want=1"); end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < RN; i++) model[i] = '0;
    n_checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin
      n_fail++; $display("FAIL midrst_ctrl got=%b want=0111", {bvalid, awready, wready, arready});
    end
    n_checks++;
    if (reg_out !== '0) begin n_fail++; $display("FAIL midrst_reg_out got=%h want=0", reg_out); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (reg_out !== model_vec() || bvalid || wr_pulse) begin
      n_fail++; $display("FAIL midrst_after got=%h/%b/%b want=0/0/0", reg_out, bvalid, wr_pulse);
    end
  endtask

  initial begin
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < RN; i++) model[i] = '0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_read_stall();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
